debug_dump_ctrl: RTL and testbench
==================================

// Module: debug_dump_ctrl
// PURPOSE
//  Host-side debug controller for the pipelined MIPS core. Decodes host command bytes from the UART receiver, drives
//  the core's inicio/activo/mem_in/add_in controls, and streams a state snapshot (PC, instruction, 32 registers,
//  data-memory words) to the UART transmitter. Sits between uart_rx/uart_tx and the core's debug outputs.
// PARAMETERS
//  N_MEM_WORDS    16  data-memory words dumped per frame, word addresses 0..N_MEM_WORDS-1 (1..4095)
//  INIT_CYCLES    2   cycles inicio is held high on command 'i' (>=1)
//  MAX_RUN_CYCLES 0   run-mode timeout in cycles; 0 = unlimited
// PORTS
//  clk          in   1     system clock
//  reset        in   1     synchronous, active-high reset
//  rx_data      in   8     received command byte
//  rx_done      in   1     1-cycle pulse: rx_data valid
//  tx_data      out  8     byte to transmit
//  tx_start     out  1     1-cycle pulse: start sending tx_data
//  tx_done      in   1     1-cycle pulse: transmitter finished a byte
//  pc_in        in   9     core PCF
//  instr_in     in   32    core InstrD
//  regs_in      in   1024  register bank, reg k at [32k+31:32k]
//  finalW_in    in   1     core reached end-of-program in WB
//  mem_data_in  in   32    core ReadDataM (1-cycle sync read latency)
//  inicio       out  1     core reset
//  activo       out  1     core run enable (1 = pipeline advances)
//  mem_in       out  1     1 = data-memory address taken from add_out
//  mem_write_in out  1     debugger write select; held 0
//  add_out      out  12    data-memory word address
//  busy         out  1     1 in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; inicio=1, all other outputs 0, byte index 0. First IDLE cycle after reset drives inicio=0.
//  Commands accepted only in IDLE on rx_done; all others ignored, and rx_done outside IDLE is dropped.
//   0x69 'i': INIT -> inicio=1 for INIT_CYCLES cycles, then send one ack byte 0x06, return IDLE.
//   0x63 'c': RUN -> activo=1 each cycle until finalW_in=1 (sampled every RUN cycle including the first) or the
//             timeout counter reaches MAX_RUN_CYCLES; activo drops in the same cycle the exit condition is seen.
//             Then DUMP.
//   0x73 's': STEP -> activo=1 for exactly 1 cycle, then DUMP. This is allowed even when finalW_in=1.
//  DUMP: activo=0 for the whole frame, so core outputs are stable and read live with no shadow copy.
//   Frame, MSB-first per word: 0xA5, PC zero-extended to 32b (4B), instr (4B), r0..r31 (128B), mem[0..N-1] (4N B).
//   Per byte: tx_start pulses 1 cycle with tx_data valid; the FSM waits for tx_done before issuing the next byte.
//   Stray tx_done pulses are ignored.
//   Memory words: mem_in=1 and add_out=word index. The word is latched from mem_data_in 2 cycles after add_out
//   changes (addr setup plus read latency). mem_in returns to 0 after the last memory byte.
//  States: IDLE, INIT, ACK, RUN, STEP, SEND, WAIT_TX, MEM_ADDR, MEM_WAIT.
//  Byte index width = $clog2(frame length + 1). The timeout counter is 32b and saturates.
//  Reset mid-operation: immediate return to reset values. A tx_done arriving afterwards is ignored.
//  Frame byte count = 137 + 4*N_MEM_WORDS (+1 with checksum).
// CONFIGURATION
//  DBG_CHECKSUM_EN defined: one extra trailing byte = XOR of every frame byte from 0xA5 through the last memory
//   byte; not added to ACK.
//  Not defined: frame ends after the last memory byte; no checksum logic.
// STRUCTURE
//  dbg_pkg: command codes (CMD_INIT=8'h69, CMD_CONT=8'h63, CMD_STEP=8'h73), HDR=8'hA5, ACK=8'h06,
//   state encoding, fixed frame offsets (PC=1, INSTR=5, REGS=9, MEM=137).
//  Sub-module dbg_byte_sel: combinational byte mux from (index, pc_in, instr_in, regs_in, latched mem word)
//   to an 8-bit byte.
// TESTING
//  1 reset then 'i': inicio=1 for 2 cycles; one tx_start with tx_data=0x06; busy=0 afterwards.
//  2 's' with regs r5=0x12345678, PC=0x010, instr=0x8C020004: activo high exactly 1 cycle; frame bytes
//    A5,00,00,00,10,8C,02,00,04; bytes 29..32 = 12,34,56,78; total 201 bytes for N=16.
//  3 'c' with finalW_in rising after 40 cycles: activo high exactly 40 cycles, then frame; a 'c' received
//    mid-frame is ignored.
//  4 memory model mem[3]=0xDEADBEEF: frame bytes 149..152 = DE,AD,BE,EF; add_out sweeps 0..15 with mem_in=1;
//    mem_write_in stays 0.
//  5 tx_done withheld for 100 cycles on byte 7: no new tx_start; reset asserted mid-frame -> IDLE, outputs at
//    reset values, a late tx_done causes no tx_start.
//  6 DBG_CHECKSUM_EN, all inputs 0: frame is 202 bytes, last byte 0xA5.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared constants for the MIPS debug dump controller: command bytes, frame
// markers, fixed frame byte offsets and the controller state encoding.
package dbg_pkg;

  localparam logic [7:0] CMD_INIT = 8'h69;
  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] HDR      = 8'hA5;
  localparam logic [7:0] ACK      = 8'h06;

  localparam int unsigned OFF_PC    = 1;
  localparam int unsigned OFF_INSTR = 5;
  localparam int unsigned OFF_REGS  = 9;
  localparam int unsigned OFF_MEM   = 137;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_ACK, S_RUN, S_STEP, S_SEND, S_WAIT_TX, S_MEM_ADDR, S_MEM_WAIT
  } state_e;

endpackage

// File: rtl/dbg_byte_sel.sv
// Combinational frame byte mux: maps a frame byte index to the header, PC,
// instruction, register or latched memory-word byte (MSB first per word).
module dbg_byte_sel
  import dbg_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic [8:0]       pc_i,
  input  logic [31:0]      instr_i,
  input  logic [1023:0]    regs_i,
  input  logic [31:0]      mem_word_i,
  output logic [7:0]       byte_o
);

  int unsigned i;
  int unsigned ridx;
  logic [31:0] word;
  logic [1:0]  boff;

  // All section bases are 1 mod 4, so the low two bits of (i - base) give the byte lane.
  always_comb begin
    i    = 32'(idx_i);
    ridx = 0;
    word = '0;
    boff = '0;
    if (i >= OFF_MEM) begin
      word = mem_word_i;
      boff = 2'(i - OFF_MEM);
    end else if (i >= OFF_REGS) begin
      ridx = (i - OFF_REGS) >> 2;
      for (int unsigned k = 0; k < 32; k++)
        if (k == ridx) word = regs_i[32*k +: 32];
      boff = 2'(i - OFF_REGS);
    end else if (i >= OFF_INSTR) begin
      word = instr_i;
      boff = 2'(i - OFF_INSTR);
    end else if (i >= OFF_PC) begin
      word = {23'd0, pc_i};
      boff = 2'(i - OFF_PC);
    end
  end

  always_comb begin
    byte_o = '0;
    if (i == 0) byte_o = HDR;
    else begin
      case (boff)
        2'd0: byte_o = word[31:24];
        2'd1: byte_o = word[23:16];
        2'd2: byte_o = word[15:8];
        default: byte_o = word[7:0];
      endcase
    end
  end

endmodule

// File: rtl/debug_dump_ctrl.sv
// Host debug controller for the pipelined MIPS core: decodes UART commands and
// streams a PC/instr/register/memory snapshot. DBG_CHECKSUM_EN appends an XOR byte.
module debug_dump_ctrl
  import dbg_pkg::*;
#(
  parameter int N_MEM_WORDS    = 16,
  parameter int INIT_CYCLES    = 2,
  parameter int MAX_RUN_CYCLES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_done,
  input  logic [8:0]    pc_in,
  input  logic [31:0]   instr_in,
  input  logic [1023:0] regs_in,
  input  logic          finalW_in,
  input  logic [31:0]   mem_data_in,
  output logic          inicio,
  output logic          activo,
  output logic          mem_in,
  output logic          mem_write_in,
  output logic [11:0]   add_out,
  output logic          busy
);

  localparam int unsigned MEM_END = OFF_MEM + 4 * N_MEM_WORDS;
`ifdef DBG_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = MEM_END + 1;
`else
  localparam int unsigned FRAME_LEN = MEM_END;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_MEM     = IDX_W'(OFF_MEM);
  localparam logic [IDX_W-1:0] IDX_MEM_END = IDX_W'(MEM_END);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(FRAME_LEN);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc, mem_off;
  logic [31:0]      cnt_q, cnt_d;
  logic [11:0]      add_q, add_d;
  logic             mem_in_q, mem_in_d, ack_q, ack_d, boot_q;
  logic [31:0]      mem_word_q;
  logic [7:0]       sel_byte, frame_byte;
  logic             run_exit;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  dbg_byte_sel #(.IDX_W(IDX_W)) u_sel (
    .idx_i(idx_q), .pc_i(pc_in), .instr_i(instr_in), .regs_i(regs_in),
    .mem_word_i(mem_word_q), .byte_o(sel_byte)
  );

  assign idx_inc  = idx_q + IDX_W'(1);
  assign mem_off  = idx_inc - IDX_MEM;
  assign run_exit = finalW_in || ((MAX_RUN_CYCLES != 0) && (cnt_q == 32'(MAX_RUN_CYCLES)));
`ifdef DBG_CHECKSUM_EN
  assign frame_byte = (idx_q == IDX_MEM_END) ? csum_q : sel_byte;
`else
  assign frame_byte = sel_byte;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    add_d    = add_q;
    mem_in_d = mem_in_q;
    ack_d    = ack_q;
    inicio   = boot_q;
    activo   = 1'b0;
    tx_start = 1'b0;
    tx_data  = '0;
`ifdef DBG_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        ack_d = 1'b0;
`ifdef DBG_CHECKSUM_EN
        csum_d = '0;
`endif
        if (rx_done) begin
          case (rx_data)
            CMD_INIT: state_d = S_INIT;
            CMD_CONT: state_d = S_RUN;
            CMD_STEP: state_d = S_STEP;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_INIT: begin
        inicio = 1'b1;
        cnt_d  = cnt_q + 32'd1;
        if (cnt_q == 32'(INIT_CYCLES - 1)) state_d = S_ACK;
      end
      S_ACK: begin
        tx_start = 1'b1;
        tx_data  = ACK;
        ack_d    = 1'b1;
        state_d  = S_WAIT_TX;
      end
      S_RUN: begin
        if (run_exit) state_d = S_SEND;
        else begin
          activo = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        end
      end
      S_STEP: begin
        activo  = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_start = 1'b1;
        tx_data  = frame_byte;
        state_d  = S_WAIT_TX;
`ifdef DBG_CHECKSUM_EN
        csum_d   = csum_q ^ frame_byte;
`endif
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          if (ack_q) state_d = S_IDLE;
          else begin
            idx_d = idx_inc;
            if (idx_inc == IDX_MEM_END) mem_in_d = 1'b0;
            if (idx_inc == IDX_LAST) state_d = S_IDLE;
            else if (idx_inc >= IDX_MEM && idx_inc < IDX_MEM_END && mem_off[1:0] == 2'b00) begin
              state_d  = S_MEM_ADDR;
              add_d    = 12'(mem_off >> 2);
              mem_in_d = 1'b1;
            end else state_d = S_SEND;
          end
        end
      end
      // Address settles this cycle; memory returns the word one cycle later.
      S_MEM_ADDR: state_d = S_MEM_WAIT;
      S_MEM_WAIT: state_d = S_SEND;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      add_q    <= '0;
      mem_in_q <= 1'b0;
      ack_q    <= 1'b0;
      boot_q   <= 1'b1;
`ifdef DBG_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      add_q    <= add_d;
      mem_in_q <= mem_in_d;
      ack_q    <= ack_d;
      boot_q   <= 1'b0;
`ifdef DBG_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_MEM_WAIT) mem_word_q <= mem_data_in;
  end

  assign add_out      = add_q;
  assign mem_in       = mem_in_q;
  assign mem_write_in = 1'b0;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Self-checking bench for debug_dump_ctrl: UART transmitter and core/memory models,
// frames compared against a byte list built directly from the snapshot contents.
module tb_debug_dump_ctrl;

  logic          clk = 1'b0;
  logic          reset, rx_done, tx_start, tx_done, finalW_in;
  logic          inicio, activo, mem_in, mem_write_in, busy;
  logic [7:0]    rx_data, tx_data;
  logic [8:0]    pc_in;
  logic [31:0]   instr_in, mem_data_in;
  logic [1023:0] regs_in;
  logic [11:0]   add_out;
  logic [31:0]   mem_arr [16];

  int n_cmp = 0, n_fail = 0;
  logic [7:0]  byte_q [$];
  logic [7:0]  exp_q [$];
  logic [11:0] addr_q [$];
  int act_cnt, ini_cnt, mw_bad, tx_cnt, run_len;
  bit hold_tx, core_moves;

  debug_dump_ctrl dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .pc_in(pc_in), .instr_in(instr_in), .regs_in(regs_in), .finalW_in(finalW_in),
    .mem_data_in(mem_data_in), .inicio(inicio), .activo(activo), .mem_in(mem_in),
    .mem_write_in(mem_write_in), .add_out(add_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Data memory with one cycle of synchronous read latency.
  always @(posedge clk) mem_data_in <= (add_out < 12'd16) ? mem_arr[add_out[3:0]] : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] got(input int i);
    return (i < byte_q.size()) ? 64'(byte_q[i]) : 64'hFFFF;
  endfunction

  // One clock: sample outputs at negedge, then drive inputs for the next posedge.
  task automatic cyc();
    @(negedge clk);
    if (tx_start) byte_q.push_back(tx_data);
    if (activo) act_cnt++;
    if (inicio) ini_cnt++;
    if (mem_write_in !== 1'b0) mw_bad++;
    if (mem_in && (addr_q.size() == 0 || addr_q[$] != add_out)) addr_q.push_back(add_out);
    rx_done = 1'b0;
    tx_done = 1'b0;
    if (activo && core_moves) begin
      pc_in    = 9'($urandom);
      instr_in = $urandom;
    end
    finalW_in = (act_cnt >= run_len);
    if (tx_cnt > 0 && !hold_tx) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    if (tx_start) tx_cnt = $urandom_range(2, 4);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic build_exp();
`ifdef DBG_CHECKSUM_EN
    logic [7:0] x;
`endif
    exp_q.delete();
    exp_q.push_back(8'hA5);
    push_word({23'd0, pc_in});
    push_word(instr_in);
    for (int r = 0; r < 32; r++) push_word(regs_in[32*r +: 32]);
    for (int m = 0; m < 16; m++) push_word(mem_arr[m]);
`ifdef DBG_CHECKSUM_EN
    x = '0;
    foreach (exp_q[k]) x ^= exp_q[k];
    exp_q.push_back(x);
`endif
  endtask

  task automatic randomize_core();
    pc_in    = 9'($urandom);
    instr_in = $urandom;
    for (int r = 0; r < 32; r++) regs_in[32*r +: 32] = $urandom;
    for (int m = 0; m < 16; m++) mem_arr[m] = $urandom;
  endtask

  task automatic do_dump(input string tag, input logic [7:0] cmd, input int rl,
                         input int exp_act, input bit inject);
    bit injected;
    int k;
    injected = 1'b0;
    byte_q.delete();
    addr_q.delete();
    act_cnt = 0;
    mw_bad  = 0;
    run_len = rl;
    finalW_in = (rl == 0);
    rx_data = cmd;
    rx_done = 1'b1;
    cyc();
    k = 0;
    while (busy && k < 20000) begin
      cyc();
      k++;
      if (inject && !injected && byte_q.size() == 50) begin
        rx_data  = 8'h63;
        rx_done  = 1'b1;
        injected = 1'b1;
      end
    end
    chk({tag, "_done"}, 64'(busy), 64'd0);
    build_exp();
    chk({tag, "_len"}, 64'(byte_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) chk($sformatf("%s_byte%0d", tag, i), got(i), 64'(exp_q[i]));
    chk({tag, "_activo"}, 64'(act_cnt), 64'(exp_act));
    chk({tag, "_memwr"}, 64'(mw_bad), 64'd0);
    chk({tag, "_memin_end"}, 64'(mem_in), 64'd0);
    chk({tag, "_addr_cnt"}, 64'(addr_q.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_addr%0d", tag, i), (i < addr_q.size()) ? 64'(addr_q[i]) : 64'hFFFF, 64'(i));
  endtask

  initial begin
    logic [7:0] hdr_exp [9];
    int k;
    reset = 1'b1; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0; finalW_in = 1'b0;
    pc_in = '0; instr_in = '0; regs_in = '0;
    for (int m = 0; m < 16; m++) mem_arr[m] = '0;
    act_cnt = 0; ini_cnt = 0; mw_bad = 0; tx_cnt = 0; run_len = 0;
    hold_tx = 1'b0; core_moves = 1'b0;

    // Reset values
    repeat (3) cyc();
    chk("rst_inicio", 64'(inicio), 64'd1);
    chk("rst_activo", 64'(activo), 64'd0);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_in", 64'(mem_in), 64'd0);
    chk("rst_add_out", 64'(add_out), 64'd0);
    chk("rst_mem_wr", 64'(mem_write_in), 64'd0);
    reset = 1'b0;
    repeat (3) cyc();
    chk("boot_inicio", 64'(inicio), 64'd0);

    // Stray tx_done and an unknown command are ignored in IDLE
    byte_q.delete();
    tx_done = 1'b1; cyc();
    rx_data = 8'h41; rx_done = 1'b1;
    repeat (5) cyc();
    chk("idle_ignore_busy", 64'(busy), 64'd0);
    chk("idle_ignore_tx", 64'(byte_q.size()), 64'd0);

    // 'i': inicio pulse then a single ACK byte
    byte_q.delete(); ini_cnt = 0;
    rx_data = 8'h69; rx_done = 1'b1; cyc();
    for (int j = 0; j < 200 && busy; j++) cyc();
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_inicio_cycles", 64'(ini_cnt), 64'd2);
    chk("init_nbytes", 64'(byte_q.size()), 64'd1);
    chk("init_ack", got(0), 64'h06);

    // 's' with directed snapshot contents
    randomize_core();
    pc_in = 9'h010; instr_in = 32'h8C020004;
    regs_in[5*32 +: 32] = 32'h12345678;
    mem_arr[3] = 32'hDEADBEEF;
    core_moves = 1'b0;
    do_dump("step", 8'h73, 0, 1, 1'b0);
    hdr_exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h8C, 8'h02, 8'h00, 8'h04};
    for (int i = 0; i < 9; i++) chk($sformatf("step_hdr%0d", i), got(i), 64'(hdr_exp[i]));
    chk("step_r5_b0", got(29), 64'h12);
    chk("step_r5_b1", got(30), 64'h34);
    chk("step_r5_b2", got(31), 64'h56);
    chk("step_r5_b3", got(32), 64'h78);
    chk("step_mem3_b0", got(149), 64'hDE);
    chk("step_mem3_b1", got(150), 64'hAD);
    chk("step_mem3_b2", got(151), 64'hBE);
    chk("step_mem3_b3", got(152), 64'hEF);
`ifndef DBG_CHECKSUM_EN
    chk("step_total", 64'(byte_q.size()), 64'd201);
`endif

    // 'c' running 40 cycles, with a 'c' arriving mid-frame
    randomize_core();
    core_moves = 1'b1;
    do_dump("cont40", 8'h63, 40, 40, 1'b1);
    repeat (30) cyc();
    chk("cont40_after_busy", 64'(busy), 64'd0);
    chk("cont40_after_bytes", 64'(byte_q.size()), 64'(exp_q.size()));

    // Randomized commands and run lengths
    for (int it = 0; it < 4; it++) begin
      bit is_step;
      int rl;
      randomize_core();
      is_step = 1'($urandom);
      rl = is_step ? 0 : $urandom_range(0, 60);
      do_dump($sformatf("rnd%0d", it), is_step ? 8'h73 : 8'h63, rl, is_step ? 1 : rl, 1'b0);
    end

`ifdef DBG_CHECKSUM_EN
    pc_in = '0; instr_in = '0; regs_in = '0;
    for (int m = 0; m < 16; m++) mem_arr[m] = '0;
    core_moves = 1'b0;
    do_dump("csum", 8'h73, 0, 1, 1'b0);
    chk("csum_total", 64'(byte_q.size()), 64'd202);
    chk("csum_last", got(201), 64'hA5);
`endif

    // tx_done withheld on byte 7, then reset mid-frame and a late tx_done
    core_moves = 1'b0;
    byte_q.delete();
    run_len = 0; finalW_in = 1'b1;
    rx_data = 8'h73; rx_done = 1'b1; cyc();
    k = 0;
    while (byte_q.size() < 8 && k < 2000) begin
      cyc();
      k++;
    end
    chk("hold_reached", 64'(byte_q.size()), 64'd8);
    hold_tx = 1'b1;
    repeat (100) cyc();
    chk("hold_no_start", 64'(byte_q.size()), 64'd8);
    chk("hold_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    repeat (2) cyc();
    chk("midrst_inicio", 64'(inicio), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_activo", 64'(activo), 64'd0);
    chk("midrst_mem_in", 64'(mem_in), 64'd0);
    chk("midrst_tx_start", 64'(tx_start), 64'd0);
    chk("midrst_add_out", 64'(add_out), 64'd0);
    reset = 1'b0; hold_tx = 1'b0; tx_cnt = 0;
    cyc();
    tx_done = 1'b1;
    repeat (20) cyc();
    chk("late_done_bytes", 64'(byte_q.size()), 64'd8);
    chk("late_done_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
